// File: rtl/alu_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// alu_seq_ctrl_if
// Command/response bundle between a host (master) and alu_seq_ctrl (slave).
//   cmd_*  : one command per valid/ready handshake (op, rd, rs1, rs2, imm,
//            carry-in, borrow-in)
//   rsp_*  : one response per command (data, error flag), valid/ready
// ---------------------------------------------------------------------------
interface alu_seq_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [2:0]  cmd_rd;
  logic [2:0]  cmd_rs1;
  logic [2:0]  cmd_rs2;
  logic [15:0] cmd_imm;
  logic        cmd_cin;
  logic        cmd_bin;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm, cmd_cin, cmd_bin,
    input  cmd_ready,
    input  rsp_valid, rsp_data, rsp_err,
    output rsp_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm, cmd_cin, cmd_bin,
    output cmd_ready,
    output rsp_valid, rsp_data, rsp_err,
    input  rsp_ready
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// alu_seq_ctrl
// Single-issue sequencer owning an 8x16 register file and the inputs of an
// external combinational 16-bit ALU.
//   clk, rst         : clock and synchronous active-high reset
//   bus (slave)      : command in / response out, valid/ready handshakes
//   alu_op_code/rs1/rs2/cin/bin : registered drive to the ALU
//   alu_result       : combinational ALU result, captured after EXEC_CYCLES
//   busy             : controller not in IDLE
// Flow: IDLE -> (EXEC ->) WB -> RSP -> IDLE, or IDLE -> RSP on error.
// ---------------------------------------------------------------------------
module alu_seq_ctrl #(
  parameter int EXEC_CYCLES = 2,
  parameter int NREG        = 8
) (
  input  logic           clk,
  input  logic           rst,
  alu_seq_ctrl_if.slave  bus,
  output logic [3:0]     alu_op_code,
  output logic [15:0]    alu_rs1,
  output logic [15:0]    alu_rs2,
  output logic           alu_cin,
  output logic           alu_bin,
  input  logic [15:0]    alu_result,
  output logic           busy
);

  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_LOADI = 4'd15;
  localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB, S_RSP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  rd_q, rd_d;
  logic [15:0] result_q, result_d;
  logic [15:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;
  logic [3:0]  alu_op_q, alu_op_d;
  logic [15:0] alu_rs1_q, alu_rs1_d;
  logic [15:0] alu_rs2_q, alu_rs2_d;
  logic        alu_cin_q, alu_cin_d;
  logic        alu_bin_q, alu_bin_d;
  logic [15:0] regs_q [NREG];
  logic        wb_en;

  logic [15:0] rs1_val, rs2_val;
  logic        op_alu;

  // r0 is hard-wired to zero on the read side; writes to it are dropped below.
  assign rs1_val = (bus.cmd_rs1 == 3'd0) ? 16'd0 : regs_q[bus.cmd_rs1];
  assign rs2_val = (bus.cmd_rs2 == 3'd0) ? 16'd0 : regs_q[bus.cmd_rs2];
  assign op_alu  = (bus.cmd_op <= 4'd4);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_d       = rd_q;
    result_d   = result_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    alu_op_d   = alu_op_q;
    alu_rs1_d  = alu_rs1_q;
    alu_rs2_d  = alu_rs2_q;
    alu_cin_d  = alu_cin_q;
    alu_bin_d  = alu_bin_q;
    wb_en      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          rd_d = bus.cmd_rd;
          if (bus.cmd_op == OP_LOADI) begin
            result_d = bus.cmd_imm;
            state_d  = S_WB;
          end else if (!op_alu || (bus.cmd_op == OP_DIV && rs2_val == 16'd0)) begin
            // Errors skip the ALU entirely, so its inputs keep their old values.
            rsp_data_d = 16'd0;
            rsp_err_d  = 1'b1;
            state_d    = S_RSP;
          end else begin
            alu_op_d  = bus.cmd_op;
            alu_rs1_d = rs1_val;
            alu_rs2_d = rs2_val;
            alu_cin_d = bus.cmd_cin;
            alu_bin_d = bus.cmd_bin;
            cnt_d     = CNT_INIT;
            state_d   = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        // ALU inputs have been stable for EXEC_CYCLES cycles when cnt reaches 0.
        if (cnt_q == 4'd0) begin
          result_d = alu_result;
          state_d  = S_WB;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_WB: begin
        wb_en      = (rd_q != 3'd0);
        rsp_data_d = result_q;
        rsp_err_d  = 1'b0;
        state_d    = S_RSP;
      end
      S_RSP: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rd_q       <= '0;
      result_q   <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      alu_op_q   <= '0;
      alu_rs1_q  <= '0;
      alu_rs2_q  <= '0;
      alu_cin_q  <= 1'b0;
      alu_bin_q  <= 1'b0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      result_q   <= result_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      alu_op_q   <= alu_op_d;
      alu_rs1_q  <= alu_rs1_d;
      alu_rs2_q  <= alu_rs2_d;
      alu_cin_q  <= alu_cin_d;
      alu_bin_q  <= alu_bin_d;
      if (wb_en) regs_q[rd_q] <= result_q;
    end
  end

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = (state_q == S_RSP);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign busy          = (state_q != S_IDLE);
  assign alu_op_code   = alu_op_q;
  assign alu_rs1       = alu_rs1_q;
  assign alu_rs2       = alu_rs2_q;
  assign alu_cin       = alu_cin_q;
  assign alu_bin       = alu_bin_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_seq_ctrl
// Drives alu_seq_ctrl with directed and random commands. A behavioural ALU
// answers alu_result; a register-array reference model predicts each
// response, its latency and the ALU drive.
// ---------------------------------------------------------------------------
module tb_alu_seq_ctrl;
  localparam int EXEC_CYCLES = 2;

  logic        clk;
  logic        rst;
  logic [3:0]  alu_op_code;
  logic [15:0] alu_rs1, alu_rs2, alu_result;
  logic        alu_cin, alu_bin, busy;

  alu_seq_ctrl_if bus ();

  alu_seq_ctrl #(.EXEC_CYCLES(EXEC_CYCLES), .NREG(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .alu_op_code (alu_op_code),
    .alu_rs1     (alu_rs1),
    .alu_rs2     (alu_rs2),
    .alu_cin     (alu_cin),
    .alu_bin     (alu_bin),
    .alu_result  (alu_result),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: plain integer arithmetic truncated to 16 bits.
  function automatic logic [15:0] ref_arith(input logic [3:0] op, input int unsigned a,
                                            input int unsigned b, input int unsigned ci,
                                            input int unsigned bi);
    int unsigned r;
    case (op)
      4'd0: r = a + b + ci;
      4'd1: r = a - b - bi;
      4'd2: r = a * b;
      4'd3: r = (b == 0) ? 0 : a / b;
      4'd4: r = (a < b) ? 1 : 0;
      default: r = 0;
    endcase
    return 16'(r & 32'hFFFF);
  endfunction

  assign alu_result = ref_arith(alu_op_code, alu_rs1, alu_rs2, alu_cin, alu_bin);

  int errors = 0;
  int checks = 0;
  logic [15:0] mregs [8];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_ready"}, bus.cmd_ready, 1);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_rspv"},  bus.rsp_valid, 0);
    chk({tag, "_rspd"},  bus.rsp_data, 0);
    chk({tag, "_rspe"},  bus.rsp_err, 0);
    chk({tag, "_aluop"}, alu_op_code, 0);
    chk({tag, "_alua"},  alu_rs1, 0);
    chk({tag, "_alub"},  alu_rs2, 0);
    chk({tag, "_alucb"}, {alu_cin, alu_bin}, 0);
  endtask

  task automatic run_cmd(input string tag, input logic [3:0] op, input logic [2:0] rd,
                         input logic [2:0] rs1, input logic [2:0] rs2, input logic [15:0] imm,
                         input logic cin, input logic bin, input int hold);
    logic [15:0] a, b, exp_data;
    logic        exp_err, alu_path;
    int          exp_lat, lat, w;
    a = mregs[rs1];
    b = mregs[rs2];
    alu_path = 1'b0;
    exp_err  = 1'b0;
    exp_data = 16'd0;
    if (op == 4'd15) begin
      exp_data = imm;
      exp_lat  = 2;
    end else if (op > 4'd4 || (op == 4'd3 && b == 16'd0)) begin
      exp_err  = 1'b1;
      exp_lat  = 1;
    end else begin
      alu_path = 1'b1;
      exp_data = ref_arith(op, a, b, cin, bin);
      exp_lat  = EXEC_CYCLES + 2;
    end

    bus.cmd_op = op; bus.cmd_rd = rd; bus.cmd_rs1 = rs1; bus.cmd_rs2 = rs2;
    bus.cmd_imm = imm; bus.cmd_cin = cin; bus.cmd_bin = bin;
    bus.cmd_valid = 1'b1;
    w = 0;
    while (!bus.cmd_ready && w < 64) begin tick(); w++; end
    if (w >= 64) chk({tag, "_ready_timeout"}, 0, 1);
    tick();
    bus.cmd_valid = 1'b0;

    lat = 1;
    while (!bus.rsp_valid && lat < 64) begin
      if (alu_path && lat <= EXEC_CYCLES) begin
        chk({tag, "_aluop"}, alu_op_code, op);
        chk({tag, "_alua"},  alu_rs1, a);
        chk({tag, "_alub"},  alu_rs2, b);
        chk({tag, "_alucb"}, {alu_cin, alu_bin}, {cin, bin});
      end
      tick();
      lat++;
    end
    chk({tag, "_lat"},  lat, exp_lat);
    chk({tag, "_data"}, bus.rsp_data, exp_data);
    chk({tag, "_err"},  bus.rsp_err, exp_err);

    for (int i = 0; i < hold; i++) begin
      chk({tag, "_hold_v"},   bus.rsp_valid, 1);
      chk({tag, "_hold_d"},   bus.rsp_data, exp_data);
      chk({tag, "_hold_rdy"}, bus.cmd_ready, 0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk({tag, "_post_v"},   bus.rsp_valid, 0);
    chk({tag, "_post_rdy"}, bus.cmd_ready, 1);

    if (!exp_err && rd != 3'd0) mregs[rd] = exp_data;
  endtask

  // ADD into r0 with rs2=r0: returns r[src] without writing anything.
  task automatic read_reg(input string tag, input logic [2:0] src);
    run_cmd(tag, 4'd0, 3'd0, src, 3'd0, 16'd0, 1'b0, 1'b0, 0);
  endtask

  initial begin
    logic [3:0]  op;
    logic [15:0] imm;
    int          sel;
    for (int i = 0; i < 8; i++) mregs[i] = 16'd0;
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_rd = '0; bus.cmd_rs1 = '0;
    bus.cmd_rs2 = '0; bus.cmd_imm = '0; bus.cmd_cin = 1'b0; bus.cmd_bin = 1'b0;
    bus.rsp_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check_reset("reset");

    run_cmd("loadi_r1", 4'd15, 3'd1, 3'd0, 3'd0, 16'h1234, 1'b0, 1'b0, 0);
    run_cmd("loadi_r2", 4'd15, 3'd2, 3'd0, 3'd0, 16'h0010, 1'b0, 1'b0, 0);
    run_cmd("add_cin",  4'd0,  3'd3, 3'd1, 3'd2, 16'd0,    1'b1, 1'b0, 0);
    chk("add_r3_value", mregs[3], 16'h1245);
    read_reg("read_r3", 3'd3);
    run_cmd("div_zero", 4'd3,  3'd4, 3'd1, 3'd0, 16'd0,    1'b0, 1'b0, 0);
    read_reg("read_r4", 3'd4);
    run_cmd("illegal7", 4'd7,  3'd1, 3'd1, 3'd2, 16'd0,    1'b0, 1'b0, 0);
    run_cmd("loadi_r0", 4'd15, 3'd0, 3'd0, 3'd0, 16'hFFFF, 1'b0, 1'b0, 0);
    read_reg("read_r0", 3'd0);
    run_cmd("sub_bin",  4'd1,  3'd5, 3'd2, 3'd1, 16'd0,    1'b0, 1'b1, 0);
    run_cmd("cmp",      4'd4,  3'd6, 3'd2, 3'd1, 16'd0,    1'b0, 1'b0, 0);
    run_cmd("self_rd",  4'd0,  3'd1, 3'd1, 3'd1, 16'd0,    1'b1, 1'b0, 0);
    run_cmd("mul_hold", 4'd2,  3'd7, 3'd1, 3'd2, 16'd0,    1'b0, 1'b0, 5);

    // Reset while the MUL is in EXEC: nothing may be written back.
    bus.cmd_op = 4'd2; bus.cmd_rd = 3'd5; bus.cmd_rs1 = 3'd1; bus.cmd_rs2 = 3'd2;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    chk("rst_exec_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset("rst_exec");
    for (int i = 0; i < 8; i++) mregs[i] = 16'd0;
    read_reg("read_r5_after_rst", 3'd5);
    read_reg("read_r1_after_rst", 3'd1);

    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 4)      op = 4'(sel);
      else if (sel == 7) op = 4'($urandom_range(5, 14));
      else if (sel == 8) op = 4'd3;
      else               op = 4'd15;
      imm = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom);
      run_cmd($sformatf("rnd%0d", n), op, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
              3'($urandom_range(0, 7)), imm, 1'($urandom), 1'($urandom), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
Single-issue sequencer that owns the 16-bit ALU datapath (add/sub/mul/div/compare) and an 8x16 register file.
- Accepts one command at a time over a valid/ready handshake.
- Reads operands, drives the ALU for a fixed settle window, captures the result, writes it back and returns a response.
- Sits between a host/command source and the combinational ALU; it is the only driver of the ALU inputs.

Parameters:
EXEC_CYCLES, 2, cycles the ALU inputs are held stable before alu_result is captured (covers the mul/div path); legal range 1..15
NREG, 8, register file depth (fixed, index width 3)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept a command
cmd_op  in  4  0=ADD 1=SUB 2=MUL 3=DIV 4=CMP 15=LOADI; others illegal
cmd_rd  in  3  destination register
cmd_rs1  in  3  source register 1
cmd_rs2  in  3  source register 2
cmd_imm  in  16  immediate for LOADI
cmd_cin  in  1  carry-in for ADD
cmd_bin  in  1  borrow-in for SUB
rsp_valid  out  1  response present
rsp_ready  in  1  response consumer ready
rsp_data  out  16  result written, or 0 on error
rsp_err  out  1  1 = illegal op or divide-by-zero
alu_op_code  out  4  to ALU op_code
alu_rs1  out  16  to ALU rs1_in
alu_rs2  out  16  to ALU rs2_in
alu_cin  out  1  to ALU cin
alu_bin  out  1  to ALU bin
alu_result  in  16  from ALU result
busy  out  1  state != IDLE

Behaviour:
Clock, reset and ALU drive
- One clock, clk.
- Reset is synchronous and active-high on rst.
- On reset:
  - state=IDLE
  - all registers r0..r7 = 0
  - rsp_valid=0, rsp_data=0, rsp_err=0
  - alu_op_code=0, alu_rs1=0, alu_rs2=0, alu_cin=0, alu_bin=0
  - busy=0, cmd_ready=1 in the first cycle after reset
- ALU outputs are registered copies of the latched command. They change only on command accept and hold through EXEC.

Register r0
- Reads as 0 always.
- Writes to r0 are discarded, but the response still carries the computed value.

States
- IDLE
  - cmd_ready=1.
  - Accept when cmd_valid && cmd_ready. Latch op, rd, cin and bin; latch operands r[rs1] and r[rs2].
  - LOADI: result = cmd_imm; go to WB.
  - Illegal op: rsp_data=0, rsp_err=1; go to RSP. No writeback.
  - DIV with r[rs2]==0: rsp_data=0, rsp_err=1; go to RSP. The ALU is not exercised. No writeback.
  - Otherwise: load cnt=EXEC_CYCLES-1; go to EXEC.
- EXEC
  - cmd_ready=0.
  - When cnt==0: capture alu_result into the result register and go to WB. Otherwise cnt--.
  - CMP captures alu_result as-is; the ALU supplies the compare bit in bit 0, upper bits 0.
- WB
  - r[rd] <= result (unless rd==0).
  - rsp_data <= result, rsp_err <= 0; go to RSP.
- RSP
  - rsp_valid=1; rsp_data and rsp_err held stable.
  - When rsp_ready: rsp_valid drops next cycle and state goes to IDLE.

Latency (accept edge = cycle 0)
- ALU op: rsp_valid rises at cycle EXEC_CYCLES+2.
- LOADI: cycle 2.
- Error: cycle 1.
- Next accept: earliest the cycle after the rsp handshake. No overlap and no hazards; a following command always sees the prior writeback.

Arithmetic and boundary rules
- No width changes in the controller. Overflow, wrap and truncation are the ALU's behaviour, passed through unmodified.
- cmd_valid while not in IDLE is ignored (cmd_ready=0); the source must hold it.
- rs1==rs2==rd is legal: operands are latched before writeback.
- rsp_ready held low: stay in RSP indefinitely with outputs stable.
- rst in any state (incl. mid-EXEC or RSP): abort, no writeback, full reset values next cycle.

Test Plan:
1. Reset, then LOADI r1=0x1234 and LOADI r2=0x0010 -> rsp_data=0x1234 then 0x0010; err=0; each response at cycle 2 after accept.
2. ADD rd=3, rs1=1, rs2=2, cin=1 (EXEC_CYCLES=2) -> alu_op_code=0, alu_rs1=0x1234, alu_rs2=0x0010 held 2 cycles; rsp_valid at cycle 4; rsp_data=0x1245; r3=0x1245 visible to the next command.
3. DIV rd=4, rs1=1, rs2=0 -> rsp_valid at cycle 1; rsp_err=1, rsp_data=0; r4 unchanged (0).
4. cmd_op=7 -> rsp_err=1 at cycle 1, no register modified. Then LOADI rd=0 imm=0xFFFF -> rsp_data=0xFFFF, but a subsequent ADD with rs1=0 reads 0.
5. MUL with rsp_ready held low 5 cycles -> rsp_valid, rsp_data and cmd_ready=0 stable throughout; IDLE one cycle after rsp_ready=1.
6. MUL started, rst asserted in EXEC -> next cycle all outputs at reset values; destination register reads 0.
